// File: rtl/io_uart_port_if.sv
// io_uart_port_if: CPU IO bus bundle between the core and the UART port.
// The master drives strobes, address and write data; the slave returns read data.
interface io_uart_port_if #(
    parameter int ADDR_W = 8
);
    logic              io_we;
    logic              io_re;
    logic [ADDR_W-1:0] io_addr;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;

    modport master (
        output io_we, io_re, io_addr, io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_we, io_re, io_addr, io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/io_uart_port.sv
// io_uart_port: memory-mapped 8N1 UART with TX, RX and a 4-register IO map.
// irr is a registered level built from rx_valid/tx_done and their enables.
module io_uart_port #(
    parameter int CLK_PER_BIT = 868,
    parameter int ADDR_W      = 8
) (
    input  logic          clk,
    input  logic          reset,
    io_uart_port_if.slave bus,
    output logic          irr,
    output logic          uart_tx,
    input  logic          uart_rx
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic sel_tx, sel_st, sel_rx, sel_ct;
    logic wr_tx, wr_ct, rd_st, rd_rx;
    logic unused_wdata;

    assign sel_tx = bus.io_addr == ADDR_W'(0);
    assign sel_st = bus.io_addr == ADDR_W'(1);
    assign sel_rx = bus.io_addr == ADDR_W'(2);
    assign sel_ct = bus.io_addr == ADDR_W'(3);
    assign wr_tx  = bus.io_we & sel_tx;
    assign wr_ct  = bus.io_we & sel_ct;
    assign rd_st  = bus.io_re & sel_st;
    assign rd_rx  = bus.io_re & sel_rx;
    assign unused_wdata = ^bus.io_wdata[31:8];

    state_t        tx_st, tx_st_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shr, tx_shr_n;
    logic          tx_line_n, tx_fin, tx_busy, tx_done;

    assign tx_busy = tx_st != IDLE;

    always_comb begin
        tx_st_n   = tx_st;
        tx_cnt_n  = tx_cnt + 1'b1;
        tx_idx_n  = tx_idx;
        tx_shr_n  = tx_shr;
        tx_line_n = uart_tx;
        tx_fin    = 1'b0;
        unique case (tx_st)
            IDLE: begin
                tx_cnt_n = '0;
                if (wr_tx) begin
                    tx_st_n   = START;
                    tx_shr_n  = bus.io_wdata[7:0];
                    tx_line_n = 1'b0;
                end
            end
            START: if (tx_cnt == BIT_END) begin
                tx_st_n   = DATA;
                tx_cnt_n  = '0;
                tx_idx_n  = '0;
                tx_line_n = tx_shr[0];
            end
            DATA: if (tx_cnt == BIT_END) begin
                tx_cnt_n  = '0;
                tx_idx_n  = tx_idx + 3'd1;
                tx_shr_n  = {1'b0, tx_shr[7:1]};
                tx_line_n = tx_shr[1];
                if (tx_idx == 3'd7) begin
                    tx_st_n   = STOP;
                    tx_line_n = 1'b1;
                end
            end
            STOP: if (tx_cnt == BIT_END) begin
                tx_st_n   = IDLE;
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                tx_fin    = 1'b1;
            end
            default: tx_st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st   <= IDLE;
            tx_cnt  <= '0;
            tx_idx  <= '0;
            tx_shr  <= '0;
            uart_tx <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_st   <= tx_st_n;
            tx_cnt  <= tx_cnt_n;
            tx_idx  <= tx_idx_n;
            tx_shr  <= tx_shr_n;
            uart_tx <= tx_line_n;
            if (tx_fin) tx_done <= 1'b1;
            else if (rd_st || wr_tx) tx_done <= 1'b0;
        end
    end

    state_t        rx_st, rx_st_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shr, rx_shr_n, rx_data;
    logic          rx_m, rx_s, rx_arm;
    logic          rx_commit, rx_ferr, rx_valid, rx_ovr;

    always_comb begin
        rx_st_n   = rx_st;
        rx_cnt_n  = rx_cnt + 1'b1;
        rx_idx_n  = rx_idx;
        rx_shr_n  = rx_shr;
        rx_commit = 1'b0;
        rx_ferr   = 1'b0;
        unique case (rx_st)
            IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s && rx_arm) rx_st_n = START;
            end
            START: if (rx_cnt == HALF_END) begin
                rx_cnt_n = '0;
                rx_idx_n = '0;
                rx_st_n  = rx_s ? IDLE : DATA;
            end
            DATA: if (rx_cnt == BIT_END) begin
                rx_cnt_n = '0;
                rx_shr_n = {rx_s, rx_shr[7:1]};
                rx_idx_n = rx_idx + 3'd1;
                if (rx_idx == 3'd7) rx_st_n = STOP;
            end
            STOP: if (rx_cnt == BIT_END) begin
                rx_cnt_n  = '0;
                rx_st_n   = IDLE;
                rx_commit = rx_s;
                rx_ferr   = !rx_s;
            end
            default: rx_st_n = IDLE;
        endcase
    end

    // a framing error disarms start detection until the line returns high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            rx_arm   <= 1'b1;
            rx_st    <= IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shr   <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_m   <= uart_rx;
            rx_s   <= rx_m;
            rx_st  <= rx_st_n;
            rx_cnt <= rx_cnt_n;
            rx_idx <= rx_idx_n;
            rx_shr <= rx_shr_n;
            if (rx_ferr) rx_arm <= 1'b0;
            else if (rx_s) rx_arm <= 1'b1;
            if (rx_commit) begin
                rx_data  <= rx_shr;
                rx_valid <= 1'b1;
                rx_ovr   <= rd_rx ? 1'b0 : (rx_ovr | rx_valid);
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
                rx_ovr   <= 1'b0;
            end
        end
    end

    logic [1:0]  ctrl;
    logic [31:0] rdata;

    assign bus.io_rdata = rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl  <= '0;
            rdata <= '0;
            irr   <= 1'b0;
        end else begin
            if (wr_ct) ctrl <= bus.io_wdata[1:0];
            irr <= (rx_valid & ctrl[0]) | (tx_done & ctrl[1]);
            if (bus.io_re) begin
                unique case (1'b1)
                    sel_st:  rdata <= {29'b0, rx_ovr, rx_valid, tx_busy};
                    sel_rx:  rdata <= {24'b0, rx_data};
                    sel_ct:  rdata <= {30'b0, ctrl};
                    default: rdata <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_io_uart_port.sv
// tb_io_uart_port: vector table, directed corner sequences and random
// TX/RX traffic against a frame-level reference model.
module tb_io_uart_port;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic irr, uart_tx;
    logic uart_rx = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   lat = 41;

    io_uart_port_if #(.ADDR_W(8)) bus ();

    io_uart_port #(.CLK_PER_BIT(CPB), .ADDR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .irr(irr),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.io_addr  = a;
        bus.io_wdata = d;
        bus.io_we    = 1'b1;
        tick();
        bus.io_we    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.io_addr = a;
        bus.io_re   = 1'b1;
        tick();
        bus.io_re   = 1'b0;
        d = bus.io_rdata;
    endtask

    // serial frame: start 0, data LSB first, then the given stop level
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) uart_rx = 1'b0;
            else if (i == 9) uart_rx = stop_bit;
            else uart_rx = 1'((b >> (i - 1)) & 8'd1);
            repeat (CPB) tick();
        end
        if (!stop_bit) repeat (2 * CPB) tick();
        uart_rx = 1'b1;
    endtask

    task automatic tx_expect(input logic [7:0] b, input string nm);
        logic bitv;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) bitv = 1'b0;
            else if (i == 9) bitv = 1'b1;
            else bitv = 1'((b >> (i - 1)) & 8'd1);
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("%s bit%0d", nm, i), 32'(uart_tx), 32'(bitv));
                tick();
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic        m_valid, m_ovr;
        logic [7:0]  m_data;
        int          c0, k;

        bus.io_we = 1'b0;
        bus.io_re = 1'b0;
        bus.io_addr = '0;
        bus.io_wdata = '0;

        tv[0]  = '{1'b1, 1'b0, 8'h03, 32'h3,        32'h0};
        tv[1]  = '{1'b0, 1'b1, 8'h03, 32'h0,        32'h3};
        tv[2]  = '{1'b1, 1'b0, 8'h03, 32'hFFFFFFFC, 32'h0};
        tv[3]  = '{1'b0, 1'b1, 8'h03, 32'h0,        32'h0};
        tv[4]  = '{1'b1, 1'b0, 8'h05, 32'hFF,       32'h0};
        tv[5]  = '{1'b0, 1'b1, 8'h05, 32'h0,        32'h0};
        tv[6]  = '{1'b0, 1'b1, 8'hFF, 32'h0,        32'h0};
        tv[7]  = '{1'b0, 1'b1, 8'h01, 32'h0,        32'h0};
        tv[8]  = '{1'b0, 1'b1, 8'h02, 32'h0,        32'h0};
        tv[9]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0};
        tv[10] = '{1'b1, 1'b1, 8'h03, 32'h2,        32'h0};
        tv[11] = '{1'b0, 1'b1, 8'h03, 32'h0,        32'h2};
        tv[12] = '{1'b1, 1'b0, 8'h03, 32'h0,        32'h0};

        repeat (3) tick();
        chk("reset rdata", bus.io_rdata, 32'h0);
        chk("reset irr", 32'(irr), 32'h0);
        chk("reset tx", 32'(uart_tx), 32'h1);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            bus.io_addr  = tv[i].addr;
            bus.io_wdata = tv[i].wdata;
            bus.io_we    = tv[i].we;
            bus.io_re    = tv[i].re;
            tick();
            bus.io_we = 1'b0;
            bus.io_re = 1'b0;
            if (tv[i].re) chk($sformatf("vec%0d", i), bus.io_rdata, tv[i].exp);
        end
        repeat (3) tick();
        chk("rdata hold", bus.io_rdata, 32'h2);

        // TX 0xA5 with an ignored mid-frame write and a busy STATUS read
        wr(8'h00, 32'hA5);
        fork
            tx_expect(8'hA5, "txA5");
            begin
                logic [31:0] s;
                repeat (10) tick();
                wr(8'h00, 32'h3C);
                repeat (5) tick();
                rd(8'h01, s);
                chk("tx busy", s, 32'h1);
            end
        join
        rd(8'h01, d);
        chk("tx idle status", d, 32'h0);
        chk("tx line idle", 32'(uart_tx), 32'h1);
        chk("tx no irr", 32'(irr), 32'h0);

        // RX 0x5A with rx_ie, measuring byte-complete latency via irr
        wr(8'h03, 32'h1);
        c0 = cyc;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                k = 0;
                while (irr !== 1'b1 && k < 100) begin
                    tick();
                    k++;
                end
                lat = cyc - c0 - 1;
            end
        join
        chk("rx irr", 32'(irr), 32'h1);
        chk("rx latency window",
            32'(lat >= CPB * 19 / 2 && lat <= CPB * 10 + 4), 32'h1);
        rd(8'h01, d);
        chk("rx status", d, 32'h2);
        rd(8'h02, d);
        chk("rx data 5A", d, 32'h5A);
        tick();
        chk("rx irr fall", 32'(irr), 32'h0);
        rd(8'h01, d);
        chk("rx status clr", d, 32'h0);

        // glitch and framing error, then a clean frame after re-arm
        uart_rx = 1'b0;
        tick();
        uart_rx = 1'b1;
        repeat (12) tick();
        chk("glitch irr", 32'(irr), 32'h0);
        rd(8'h01, d);
        chk("glitch status", d, 32'h0);
        send_frame(8'h5A, 1'b0);
        repeat (8) tick();
        chk("frame irr", 32'(irr), 32'h0);
        rd(8'h01, d);
        chk("frame status", d, 32'h0);
        send_frame(8'h3C, 1'b1);
        repeat (6) tick();
        rd(8'h01, d);
        chk("rearm status", d, 32'h2);
        rd(8'h02, d);
        chk("rearm data", d, 32'h3C);

        // overrun
        send_frame(8'h11, 1'b1);
        repeat (4) tick();
        send_frame(8'h22, 1'b1);
        repeat (6) tick();
        rd(8'h01, d);
        chk("ovr status", d, 32'h6);
        rd(8'h02, d);
        chk("ovr data", d, 32'h22);
        rd(8'h01, d);
        chk("ovr cleared", d, 32'h0);

        // RXDATA read on the edge that completes 0x77
        send_frame(8'h10, 1'b1);
        repeat (4) tick();
        c0 = cyc;
        fork
            send_frame(8'h77, 1'b1);
            begin
                logic [31:0] s;
                while (cyc < c0 + lat - 1) tick();
                rd(8'h02, s);
                chk("coll old byte", s, 32'h10);
            end
        join
        repeat (2) tick();
        rd(8'h01, d);
        chk("coll status", d, 32'h2);
        rd(8'h02, d);
        chk("coll new byte", d, 32'h77);
        rd(8'h01, d);
        chk("coll status clr", d, 32'h0);

        // random RX traffic against a byte/flag model
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 8'h77;
        for (int it = 0; it < 8; it++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            repeat (6 + $urandom_range(0, 7)) tick();
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_data  = b;
            if ($urandom_range(0, 1) == 1) begin
                rd(8'h01, d);
                chk("rand rx status", d, {29'b0, m_ovr, m_valid, 1'b0});
                rd(8'h02, d);
                chk("rand rx data", d, {24'b0, m_data});
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
        rd(8'h01, d);
        chk("rand rx final status", d, {29'b0, m_ovr, m_valid, 1'b0});
        rd(8'h02, d);
        chk("rand rx final data", d, {24'b0, m_data});

        // random TX traffic with tx_ie
        wr(8'h03, 32'h2);
        for (int it = 0; it < 3; it++) begin
            b = 8'($urandom_range(0, 255));
            wr(8'h00, {24'b0, b});
            tx_expect(b, "rand tx");
            chk("tx irr pending", 32'(irr), 32'h0);
            tick();
            chk("tx irr", 32'(irr), 32'h1);
            rd(8'h01, d);
            chk("tx done status", d, 32'h0);
            tick();
            chk("tx irr clr", 32'(irr), 32'h0);
        end

        // reset mid-TX-frame with irr high and io_rdata nonzero
        wr(8'h03, 32'h3);
        send_frame(8'h81, 1'b1);
        repeat (6) tick();
        chk("pre-reset irr", 32'(irr), 32'h1);
        wr(8'h00, 32'h0);
        repeat (3) tick();
        chk("pre-reset tx", 32'(uart_tx), 32'h0);
        rd(8'h03, d);
        chk("pre-reset ctrl", d, 32'h3);
        reset = 1'b0;
        #1;
        chk("async tx", 32'(uart_tx), 32'h1);
        chk("async rdata", bus.io_rdata, 32'h0);
        chk("async irr", 32'(irr), 32'h0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        rd(8'h01, d);
        chk("post-reset status", d, 32'h0);
        rd(8'h03, d);
        chk("post-reset ctrl", d, 32'h0);
        repeat (4) tick();
        chk("post-reset tx", 32'(uart_tx), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/io_uart_port.md
Name: io_uart_port

Overview:
- Memory-mapped UART peripheral that answers the CPU's IO read and IO write operations (r_io / w_io) and drives the CPU's interrupt request line (irr).
- Contains a byte-wide 8N1 transmitter, a byte-wide 8N1 receiver, and a 4-register IO map.
- Sits on the IO bus next to the CPU core and connects to the external tx/rx pins.

Parameters:
- CLK_PER_BIT, 868, clk cycles per UART bit. Legal values are ≥4 and even.
- ADDR_W, 8, IO address width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- io_we  input  1  IO write strobe, one cycle per access
- io_re  input  1  IO read strobe, one cycle per access
- io_addr  input  ADDR_W  register address
- io_wdata  input  32  write data
- io_rdata  output  32  read data, registered
- irr  output  1  interrupt request to the CPU, level-sensitive
- uart_tx  output  1  serial output, idle high
- uart_rx  input  1  serial input, asynchronous to clk

Behaviour:
- Reset values while reset=0: io_rdata=0, irr=0, uart_tx=1, TX FSM=IDLE, RX FSM=IDLE, rx_valid=0, rx_overrun=0, rx_data=0, ctrl=0. The rx synchronizer flops reset to 1.
- Reset asserted mid-frame aborts both FSMs immediately. uart_tx goes high asynchronously.
- Register map (addresses not listed read 0; writes to them are ignored):
  - 0x00 TXDATA (W): io_wdata[7:0].
  - 0x01 STATUS (R): bit0 tx_busy, bit1 rx_valid, bit2 rx_overrun, other bits 0.
  - 0x02 RXDATA (R): {24'b0, rx_data}.
  - 0x03 CTRL (R/W): bit0 rx_ie, bit1 tx_ie.
- Reads:
  - io_rdata is loaded on the edge where io_re=1, so it is valid 1 cycle later. It holds its value until the next read.
  - A read of RXDATA clears rx_valid and rx_overrun on that same edge.
- Writes:
  - A write to TXDATA while TX is IDLE latches the byte and moves TX to START on that edge.
  - A write to TXDATA while tx_busy=1 is ignored and the in-flight frame is unaffected.
  - io_we and io_re asserted together in the same cycle: both are honoured.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Each of START, DATA-bit and STOP holds uart_tx for exactly CLK_PER_BIT cycles, timed by a bit counter.
  - START drives 0. DATA drives 8 bits LSB first (3-bit index). STOP drives 1.
  - tx_busy = (state != IDLE).
  - uart_tx changes on the edge after the write, so the start bit begins 1 cycle after io_we.
  - Leaving STOP sets tx_done. tx_done is cleared by any STATUS read or TXDATA write.
- RX:
  - uart_rx passes through a 2-flop synchronizer.
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized 0 enters START.
  - START: sample at CLK_PER_BIT/2. If the sample is 1 (glitch), return to IDLE with no side effects. Otherwise sample each bit at its centre, every CLK_PER_BIT cycles.
  - STOP sample = 1: on that edge rx_data <= byte and rx_valid <= 1. If rx_valid was already 1 and no RXDATA read occurs on the same edge, set rx_overrun and overwrite rx_data.
  - STOP sample = 0 (framing error): discard the byte, leave flags unchanged, return to IDLE and wait for the line to go high before re-arming.
  - Same edge as a byte completing, an RXDATA read: io_rdata gets the old byte, the new byte is stored, rx_valid ends at 1, and no overrun is set.
- irr = registered ((rx_valid & rx_ie) | (tx_done & tx_ie)). It updates 1 cycle after its source changes and stays high until the sources are cleared.
- Counter widths: $clog2(CLK_PER_BIT) bits for the bit counter, 3 bits for the bit index. No wrap is exposed; the counters reload at each bit boundary.

Test Plan:
- Reset hold, CLK_PER_BIT=4: assert reset low mid-TX-frame -> uart_tx=1 immediately; io_rdata=0, irr=0; STATUS read after release returns 0x0.
- TX 0xA5: write 0x00 <= 0xA5 -> uart_tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. STATUS bit0=1 during the frame and 0 after. A second write mid-frame (0x3C) produces no change.
- RX 0x5A with rx_ie=1: drive the 0x5A frame on uart_rx -> rx_valid=1 and irr=1 a cycle later. Read 0x02 -> io_rdata=0x5A next cycle, then rx_valid=0 and irr falls.
- Overrun: receive 0x11 then 0x22 with no read -> STATUS=0x6. RXDATA reads 0x22; the following STATUS read returns 0x0.
- Glitch/framing: a 1-cycle low pulse on uart_rx -> no rx_valid. A frame with stop bit=0 -> rx_valid stays 0 and no irr.
- Collision: RXDATA read on the exact edge a new byte 0x77 completes (prior byte 0x10) -> io_rdata=0x10, rx_valid=1, rx_overrun=0; next RXDATA read returns 0x77.
